screen_draw_arbiter: RTL and testbench

// - Owns the single VGA pixel-write port; shares it between three full-screen image draws
//   (splash, victory, death) and the per-pixel game renderer.
// - Sequences image draws itself: raster counter, image-ROM address, ROM-latency alignment, done pulse.
// - Sits between the game FSM (requesters) and the VGA adapter; image ROMs are external, read-only.

---
 rtl/screen_draw_arbiter_pkg.sv | 29 ++
 rtl/screen_draw_arbiter_raster.sv | 49 ++++
 rtl/screen_draw_arbiter.sv | 147 ++++++++++++++
 tb/tb_screen_draw_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_draw_arbiter_pkg.sv
// Shared definitions for the screen draw arbiter slice.
//   state_t      arbiter FSM states
//   IMG_*        image IDs, also the rom_sel encoding
//   DEF_SCR_W/H  default screen geometry, FRAME_PIX pixels per image
//   grant_img    fixed-priority image grant: death > victory > splash
package screen_draw_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] IMG_SPLASH  = 2'd0;
  localparam logic [1:0] IMG_VICTORY = 2'd1;
  localparam logic [1:0] IMG_DEATH   = 2'd2;

  localparam int unsigned DEF_SCR_W = 160;
  localparam int unsigned DEF_SCR_H = 120;
  localparam int unsigned FRAME_PIX = DEF_SCR_W * DEF_SCR_H;

  function automatic logic [1:0] grant_img(input logic [2:0] req);
    if (req[2])      return IMG_DEATH;
    else if (req[1]) return IMG_VICTORY;
    else             return IMG_SPLASH;
  endfunction

endpackage

// File: rtl/screen_draw_arbiter_raster.sv
// raster_addr_gen: raster position and linear image-ROM address counter.
//   clock, resetn  system clock, async active-low reset
//   clear          restart at (0,0), addr 0
//   step           advance one pixel (x wraps to 0 with y+1)
//   x, y, addr     current raster position and y*SCR_W+x
//   last           current position is (SCR_W-1, SCR_H-1)
module raster_addr_gen
  import screen_draw_arbiter_pkg::*;
#(
  parameter int unsigned SCR_W = DEF_SCR_W,
  parameter int unsigned SCR_H = DEF_SCR_H
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear,
  input  logic        step,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [14:0] addr,
  output logic        last
);

  localparam logic [7:0] X_MAX = 8'(SCR_W - 1);
  localparam logic [6:0] Y_MAX = 7'(SCR_H - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  // addr is counted alongside x/y rather than computed, so no multiplier
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (step) begin
      addr <= addr + 15'd1;
      if (x == X_MAX) begin
        x <= '0;
        y <= y + 7'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

endmodule

// File: rtl/screen_draw_arbiter.sv
// screen_draw_arbiter: owns the VGA pixel-write port and shares it between
// three full-screen image draws and the per-pixel game renderer.
//   clock, resetn              system clock, async active-low reset
//   img_req[2:0]               level requests: splash, victory, death
//   game_req/x/y/col, game_ack game pixel write, ack is combinational
//   rom_sel, rom_addr, rom_col external image-ROM interface
//   vga_x/y/col, vga_plot      registered pixel write to the VGA adapter
//   busy, img_done             draw in progress, one-cycle completion pulse
module screen_draw_arbiter
  import screen_draw_arbiter_pkg::*;
#(
  parameter int unsigned SCR_W   = DEF_SCR_W,
  parameter int unsigned SCR_H   = DEF_SCR_H,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [2:0]  img_req,
  input  logic        game_req,
  input  logic [7:0]  game_x,
  input  logic [6:0]  game_y,
  input  logic [2:0]  game_col,
  output logic        game_ack,
  output logic [1:0]  rom_sel,
  output logic [14:0] rom_addr,
  input  logic [2:0]  rom_col,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_col,
  output logic        vga_plot,
  output logic        busy,
  output logic        img_done
);

  state_t      state, state_nx;
  logic        clear, step, last, img_grant;
  logic [7:0]  rx;
  logic [6:0]  ry;
  logic [7:0]  drain_cnt;

  logic [ROM_LAT-1:0] pv;
  logic [7:0]         px [ROM_LAT];
  logic [6:0]         py [ROM_LAT];

  raster_addr_gen #(
    .SCR_W (SCR_W),
    .SCR_H (SCR_H)
  ) u_raster (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear),
    .step   (step),
    .x      (rx),
    .y      (ry),
    .addr   (rom_addr),
    .last   (last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    game_ack  = 1'b0;
    clear     = 1'b0;
    step      = 1'b0;
    img_grant = 1'b0;
    busy      = (state != ST_IDLE);
    img_done  = (state == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (|img_req) begin
          img_grant = 1'b1;
          clear     = 1'b1;
          state_nx  = ST_FILL;
        end else if (game_req) begin
          game_ack = 1'b1;
        end
      end
      ST_FILL: begin
        // holding on the last pixel keeps rom_addr inside the image
        step = !last;
        if (last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == 8'(ROM_LAT - 1)) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rom_sel   <= IMG_SPLASH;
      drain_cnt <= '0;
    end else begin
      if (img_grant) rom_sel <= grant_img(img_req);
      if (state == ST_DRAIN) drain_cnt <= drain_cnt + 8'd1;
      else                   drain_cnt <= '0;
    end
  end

  // raster position travels alongside the ROM read so it lines up with rom_col
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pv <= '0;
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        px[i] <= '0;
        py[i] <= '0;
      end
    end else begin
      pv[0] <= (state == ST_FILL);
      px[0] <= rx;
      py[0] <= ry;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        pv[i] <= pv[i-1];
        px[i] <= px[i-1];
        py[i] <= py[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_x    <= '0;
      vga_y    <= '0;
      vga_col  <= '0;
      vga_plot <= 1'b0;
    end else if (game_ack) begin
      vga_x    <= game_x;
      vga_y    <= game_y;
      vga_col  <= game_col;
      vga_plot <= 1'b1;
    end else if (pv[ROM_LAT-1]) begin
      vga_x    <= px[ROM_LAT-1];
      vga_y    <= py[ROM_LAT-1];
      vga_col  <= rom_col;
      vga_plot <= 1'b1;
    end else begin
      vga_plot <= 1'b0;
    end
  end

endmodule

// File: tb/tb_screen_draw_arbiter.sv
module tb_screen_draw_arbiter;

  localparam int FULL = 19200;

  logic        clock = 1'b0;
  logic        resetn;
  logic [2:0]  img_req;
  logic        game_req;
  logic [7:0]  game_x;
  logic [6:0]  game_y;
  logic [2:0]  game_col;
  logic        use2;

  logic        ack1, plot1, busy1, done1;
  logic [1:0]  sel1;
  logic [14:0] addr1;
  logic [7:0]  x1;
  logic [6:0]  y1;
  logic [2:0]  col1, rom1;

  logic        ack2, plot2, busy2, done2;
  logic [1:0]  sel2;
  logic [14:0] addr2;
  logic [7:0]  x2;
  logic [6:0]  y2;
  logic [2:0]  col2, rom2, rom2a;

  logic [2:0]  req_a, req_b;
  logic        greq_a, greq_b;

  logic        m_ack, m_plot, m_busy, m_done;
  logic [1:0]  m_sel;
  logic [14:0] m_addr;
  logic [7:0]  m_x;
  logic [6:0]  m_y;
  logic [2:0]  m_col;

  logic [2:0]  rom_img [3][FULL];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  assign req_a  = use2 ? 3'b000 : img_req;
  assign req_b  = use2 ? img_req : 3'b000;
  assign greq_a = game_req & ~use2;
  assign greq_b = game_req & use2;

  assign m_ack  = use2 ? ack2  : ack1;
  assign m_plot = use2 ? plot2 : plot1;
  assign m_busy = use2 ? busy2 : busy1;
  assign m_done = use2 ? done2 : done1;
  assign m_sel  = use2 ? sel2  : sel1;
  assign m_addr = use2 ? addr2 : addr1;
  assign m_x    = use2 ? x2    : x1;
  assign m_y    = use2 ? y2    : y1;
  assign m_col  = use2 ? col2  : col1;

  screen_draw_arbiter #(.SCR_W(160), .SCR_H(120), .ROM_LAT(1)) dut1 (
    .clock(clock), .resetn(resetn), .img_req(req_a), .game_req(greq_a),
    .game_x(game_x), .game_y(game_y), .game_col(game_col), .game_ack(ack1),
    .rom_sel(sel1), .rom_addr(addr1), .rom_col(rom1),
    .vga_x(x1), .vga_y(y1), .vga_col(col1), .vga_plot(plot1),
    .busy(busy1), .img_done(done1)
  );

  screen_draw_arbiter #(.SCR_W(32), .SCR_H(24), .ROM_LAT(2)) dut2 (
    .clock(clock), .resetn(resetn), .img_req(req_b), .game_req(greq_b),
    .game_x(game_x), .game_y(game_y), .game_col(game_col), .game_ack(ack2),
    .rom_sel(sel2), .rom_addr(addr2), .rom_col(rom2),
    .vga_x(x2), .vga_y(y2), .vga_col(col2), .vga_plot(plot2),
    .busy(busy2), .img_done(done2)
  );

  // external image ROMs: 1-cycle and 2-cycle read latency
  always @(posedge clock) begin
    rom1  <= (sel1 != 2'd3 && addr1 < 15'(FULL)) ? rom_img[sel1][addr1] : 3'd0;
    rom2a <= (sel2 != 2'd3 && addr2 < 15'(FULL)) ? rom_img[sel2][addr2] : 3'd0;
    rom2  <= rom2a;
  end

  // Reference: the k-th plot of an image is (k % w, k / w) with colour ROM[k],
  // first plot lat+1 cycles after FILL entry, img_done lat+1 after last address.
  task automatic check_draw(input string name, input logic [1:0] exp_sel,
                            input int lat, input int w, input int h,
                            input logic [2:0] next_req);
    int  frame, cyc, plots, bad, addr_bad, ack_bad, busy_bad, first_cyc, done_cyc;
    bit  seen;
    frame = w * h;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clock);
      seen = (m_busy === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s busy_start: got 0 want 1", name);
      img_req = next_req;
      return;
    end
    img_req = next_req;
    checks++;
    if (m_sel !== exp_sel) begin
      errors++;
      $display("FAIL %s rom_sel: got %0d want %0d", name, m_sel, exp_sel);
    end
    cyc = 0; plots = 0; bad = 0; addr_bad = 0; ack_bad = 0; busy_bad = 0;
    first_cyc = -1; done_cyc = -1;
    while (cyc < frame + lat + 10) begin
      if (cyc < frame && m_addr !== 15'(cyc)) addr_bad++;
      if (m_ack !== 1'b0) ack_bad++;
      if (m_busy !== 1'b1) busy_bad++;
      if (m_plot === 1'b1) begin
        if (plots == 0) first_cyc = cyc;
        if (plots >= frame || m_x !== 8'(plots % w) || m_y !== 7'(plots / w) ||
            m_col !== rom_img[exp_sel][plots]) bad++;
        plots++;
      end
      if (m_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (first_cyc != lat + 1) begin
      errors++;
      $display("FAIL %s first_plot_cycle: got %0d want %0d", name, first_cyc, lat + 1);
    end
    checks++;
    if (plots != frame) begin
      errors++;
      $display("FAIL %s plot_count: got %0d want %0d", name, plots, frame);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s pixel_sequence: got %0d bad pixels want 0", name, bad);
    end
    checks++;
    if (addr_bad != 0) begin
      errors++;
      $display("FAIL %s rom_addr_sequence: got %0d bad cycles want 0", name, addr_bad);
    end
    checks++;
    if (ack_bad != 0 || busy_bad != 0) begin
      errors++;
      $display("FAIL %s ack_busy_during_draw: got ack_bad=%0d busy_bad=%0d want 0/0",
               name, ack_bad, busy_bad);
    end
    checks++;
    if (done_cyc != frame + lat) begin
      errors++;
      $display("FAIL %s img_done_cycle: got %0d want %0d", name, done_cyc, frame + lat);
    end
    @(negedge clock);
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0/0", name, m_done, m_busy);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; img_req = '0; game_req = 1'b0;
    game_x = '0; game_y = '0; game_col = '0; use2 = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({ack1, sel1, addr1, x1, y1, col1, plot1, busy1, done1} !== '0 ||
        {ack2, sel2, addr2, x2, y2, col2, plot2, busy2, done2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got plot=%b busy=%b addr=%0d want all zero",
               plot1, busy1, addr1);
    end
    resetn = 1'b1;
  endtask

  task automatic test_priority();
    @(negedge clock);
    img_req = 3'b101;
    check_draw("death_first", 2'd2, 1, 160, 120, 3'b001);
    check_draw("splash_redraw", 2'd0, 1, 160, 120, 3'b000);
  endtask

  task automatic test_reset_mid_draw();
    int plots, cyc;
    @(negedge clock);
    img_req = 3'b001;
    plots = 0; cyc = 0;
    while (plots < 5000 && cyc < 6000) begin
      @(negedge clock);
      img_req = 3'b000;
      if (plot1 === 1'b1) plots++;
      cyc++;
    end
    checks++;
    if (plots != 5000) begin
      errors++;
      $display("FAIL midreset_reach_5000: got %0d plots want 5000", plots);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({plot1, busy1, done1, ack1, addr1, x1, y1, col1, sel1} !== '0) begin
      errors++;
      $display("FAIL midreset_immediate: got plot=%b busy=%b addr=%0d x=%0d want all zero",
               plot1, busy1, addr1, x1);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (plot1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_held: got plot=%b busy=%b want 0/0", plot1, busy1);
    end
    resetn = 1'b1;
  endtask

  task automatic test_game_block();
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    @(negedge clock);
    img_req = 3'b010; game_req = 1'b1;
    game_x = 8'd10; game_y = 7'd20; game_col = 3'd5;
    #1;
    checks++;
    if (ack1 !== 1'b0) begin
      errors++;
      $display("FAIL game_vs_img_ack: got %b want 0", ack1);
    end
    check_draw("victory_restart", 2'd1, 1, 160, 120, 3'b000);
    checks++;
    if (ack1 !== 1'b1) begin
      errors++;
      $display("FAIL game_ack_after_draw: got %b want 1", ack1);
    end
    ex = 8'd10; ey = 7'd20; ec = 3'd5;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      checks++;
      if (plot1 !== 1'b1 || x1 !== ex || y1 !== ey || col1 !== ec) begin
        errors++;
        $display("FAIL game_pixel_%0d: got plot=%b (%0d,%0d,%0d) want 1 (%0d,%0d,%0d)",
                 i, plot1, x1, y1, col1, ex, ey, ec);
      end
      if (i == 11) begin
        game_req = 1'b0;
      end else begin
        ex = 8'($urandom_range(0, 159));
        ey = 7'($urandom_range(0, 119));
        ec = 3'($urandom);
        game_x = ex; game_y = ey; game_col = ec;
        #1;
        checks++;
        if (ack1 !== 1'b1) begin
          errors++;
          $display("FAIL game_ack_%0d: got %b want 1", i, ack1);
        end
      end
    end
    @(negedge clock);
    checks++;
    if (plot1 !== 1'b0) begin
      errors++;
      $display("FAIL game_idle_plot: got %b want 0", plot1);
    end
  endtask

  task automatic test_rom_lat2();
    use2 = 1'b1;
    @(negedge clock);
    img_req = 3'b011;
    check_draw("lat2_victory", 2'd1, 2, 32, 24, 3'b000);
  endtask

  task automatic test_random_requests();
    logic [2:0] r;
    logic [1:0] exp_sel;
    for (int n = 0; n < 6; n++) begin
      r = 3'($urandom_range(1, 7));
      exp_sel = r[2] ? 2'd2 : (r[1] ? 2'd1 : 2'd0);
      @(negedge clock);
      img_req = r;
      game_req = 1'($urandom);
      check_draw($sformatf("rand_req_%0d", n), exp_sel, 2, 32, 24, 3'b000);
    end
    game_req = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < FULL; k++)
        rom_img[s][k] = 3'($urandom);
    test_reset();
    test_priority();
    test_reset_mid_draw();
    test_game_block();
    test_rom_lat2();
    test_random_requests();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
